// File: rtl/tilt_line_sequencer_pkg.sv
// Shared encodings for the tilt line sequencer: FSM states, draw modes and
// the guard width used for signed endpoint arithmetic before clamping.
package tilt_line_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SAMPLE    = 3'd1,
    ST_CLEAR     = 3'd2,
    ST_WAIT_CLR  = 3'd3,
    ST_LOAD      = 3'd4,
    ST_START     = 3'd5,
    ST_WAIT_DRAW = 3'd6,
    ST_NEXT      = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    MODE_PARALLEL = 2'd0,
    MODE_ZIGZAG   = 2'd1,
    MODE_FAN      = 2'd2,
    MODE_RSVD     = 2'd3
  } mode_t;

  // Extra headroom bits so pivot + k*gap +/- scaled inc never wraps before clamping.
  localparam int CLAMP_GUARD_W = 4;

  localparam logic [7:0] DROP_MAX = 8'hFF;

endpackage

// File: rtl/tilt_line_sequencer_seg_coord_calc.sv
// Combinational endpoint generator for one segment: offsets the segment row by
// the tilt-derived delta for the selected mode and clamps to the screen.
module seg_coord_calc
  import tilt_line_sequencer_pkg::*;
#(
  parameter int P_COORD_W  = 16,
  parameter int P_SCREEN_W = 640,
  parameter int P_SCREEN_H = 480,
  parameter int P_PIVOT_X  = 325,
  parameter int P_PIVOT_Y  = 200,
  parameter int P_HALF_LEN = 75,
  parameter int P_SEG_GAP  = 40
) (
  input  logic [2:0]           k,
  input  logic [15:0]          inc,
  input  logic [1:0]           mode,
  output logic [P_COORD_W-1:0] x0,
  output logic [P_COORD_W-1:0] y0,
  output logic [P_COORD_W-1:0] x1,
  output logic [P_COORD_W-1:0] y1
);

  localparam int CW = P_COORD_W + CLAMP_GUARD_W;

  localparam logic signed [CW-1:0] PIVOT_X  = CW'(P_PIVOT_X);
  localparam logic signed [CW-1:0] PIVOT_Y  = CW'(P_PIVOT_Y);
  localparam logic signed [CW-1:0] HALF_LEN = CW'(P_HALF_LEN);
  localparam logic signed [CW-1:0] SEG_GAP  = CW'(P_SEG_GAP);
  localparam logic signed [CW-1:0] X_MAX    = CW'(P_SCREEN_W - 1);
  localparam logic signed [CW-1:0] Y_MAX    = CW'(P_SCREEN_H - 1);
  localparam logic signed [CW-1:0] ONE      = CW'(1);

  function automatic logic [P_COORD_W-1:0] clamp(input logic signed [CW-1:0] v,
                                                 input logic signed [CW-1:0] hi);
    logic [P_COORD_W-1:0] r;
    if (v[CW-1])
      r = '0;
    else if (v > hi)
      r = hi[P_COORD_W-1:0];
    else
      r = v[P_COORD_W-1:0];
    return r;
  endfunction

  logic signed [CW-1:0] inc_w;
  logic signed [CW-1:0] k_w;
  logic signed [CW-1:0] d;
  logic signed [CW-1:0] base_y;

  always_comb begin
    inc_w = {{(CW-16){inc[15]}}, inc};
    k_w   = {{(CW-3){1'b0}}, k};
    d     = inc_w;
    case (mode_t'(mode))
      MODE_ZIGZAG: if (k[0]) d = -inc_w;
      MODE_FAN:    d = inc_w * (k_w + ONE);
      default:     d = inc_w;
    endcase
    base_y = PIVOT_Y + k_w * SEG_GAP;
    y0 = clamp(base_y + d, Y_MAX);
    y1 = clamp(base_y - d, Y_MAX);
    x0 = clamp(PIVOT_X - HALF_LEN, X_MAX);
    x1 = clamp(PIVOT_X + HALF_LEN, X_MAX);
  end

endmodule

// File: rtl/tilt_line_sequencer.sv
// Per-frame sequencer: samples the tilt once per frame tick, clears the line
// drawer, then issues P_NUM_SEG segments with a start pulse each.
module tilt_line_sequencer
  import tilt_line_sequencer_pkg::*;
#(
  parameter int P_COORD_W  = 16,
  parameter int P_SCREEN_W = 640,
  parameter int P_SCREEN_H = 480,
  parameter int P_NUM_SEG  = 4,
  parameter int P_SHIFT    = 4,
  parameter int P_PIVOT_X  = 325,
  parameter int P_PIVOT_Y  = 200,
  parameter int P_HALF_LEN = 75,
  parameter int P_SEG_GAP  = 40
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [15:0]          i_x_axis,
  input  logic [1:0]           i_mode,
  input  logic                 i_frame_tick,
  input  logic                 i_waiting,
  output logic                 o_clear,
  output logic                 o_start,
  output logic [P_COORD_W-1:0] o_x0,
  output logic [P_COORD_W-1:0] o_y0,
  output logic [P_COORD_W-1:0] o_x1,
  output logic [P_COORD_W-1:0] o_y1,
  output logic                 o_busy,
  output logic [2:0]           o_seg_idx,
  output logic [7:0]           o_drop_cnt,
  output logic [2:0]           o_state
);

  localparam logic [2:0] LAST_SEG = 3'(P_NUM_SEG - 1);

  state_t      state;
  logic [15:0] inc_q;
  logic [1:0]  mode_q;
  logic        draw_armed;

  logic [P_COORD_W-1:0] calc_x0, calc_y0, calc_x1, calc_y1;

  seg_coord_calc #(
    .P_COORD_W  (P_COORD_W),
    .P_SCREEN_W (P_SCREEN_W),
    .P_SCREEN_H (P_SCREEN_H),
    .P_PIVOT_X  (P_PIVOT_X),
    .P_PIVOT_Y  (P_PIVOT_Y),
    .P_HALF_LEN (P_HALF_LEN),
    .P_SEG_GAP  (P_SEG_GAP)
  ) u_calc (
    .k    (o_seg_idx),
    .inc  (inc_q),
    .mode (mode_q),
    .x0   (calc_x0),
    .y0   (calc_y0),
    .x1   (calc_x1),
    .y1   (calc_y1)
  );

  assign o_state = state;

  // Drawer handshake: i_waiting high means the drawer is idle and ready. o_clear
  // and o_start are single-cycle requests; the drawer acknowledges completion by
  // (re)asserting i_waiting. Right after o_start the drawer may still show the
  // stale idle flag, so the first WAIT_DRAW cycle never looks at i_waiting.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      inc_q      <= '0;
      mode_q     <= '0;
      draw_armed <= 1'b0;
      o_clear    <= 1'b0;
      o_start    <= 1'b0;
      o_busy     <= 1'b0;
      o_seg_idx  <= '0;
      o_drop_cnt <= '0;
      o_x0       <= '0;
      o_y0       <= '0;
      o_x1       <= '0;
      o_y1       <= '0;
    end else begin
      o_clear <= 1'b0;
      o_start <= 1'b0;

      // o_busy is still high in the NEXT cycle that returns to IDLE, so a tick
      // landing there is dropped too.
      if (i_frame_tick && o_busy && (o_drop_cnt != DROP_MAX))
        o_drop_cnt <= o_drop_cnt + 8'd1;

      case (state)
        ST_IDLE: begin
          if (i_frame_tick) begin
            state  <= ST_SAMPLE;
            o_busy <= 1'b1;
          end
        end
        ST_SAMPLE: begin
          inc_q   <= 16'($signed(i_x_axis) >>> P_SHIFT);
          mode_q  <= i_mode;
          o_clear <= 1'b1;
          state   <= ST_CLEAR;
        end
        ST_CLEAR: begin
          state <= ST_WAIT_CLR;
        end
        ST_WAIT_CLR: begin
          if (i_waiting)
            state <= ST_LOAD;
        end
        ST_LOAD: begin
          o_x0    <= calc_x0;
          o_y0    <= calc_y0;
          o_x1    <= calc_x1;
          o_y1    <= calc_y1;
          o_start <= 1'b1;
          state   <= ST_START;
        end
        ST_START: begin
          draw_armed <= 1'b0;
          state      <= ST_WAIT_DRAW;
        end
        ST_WAIT_DRAW: begin
          if (!draw_armed)
            draw_armed <= 1'b1;
          else if (i_waiting)
            state <= ST_NEXT;
        end
        ST_NEXT: begin
          if (o_seg_idx == LAST_SEG) begin
            o_seg_idx <= '0;
            o_busy    <= 1'b0;
            state     <= ST_IDLE;
          end else begin
            o_seg_idx <= o_seg_idx + 3'd1;
            state     <= ST_LOAD;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tilt_line_sequencer.sv
// Self-checking bench for tilt_line_sequencer: vector table of known frames,
// randomized frames against a behavioural model, reset and drop-count sequences.
module tb_tilt_line_sequencer;

  localparam int NUM_SEG = 4;
  localparam int NUM_VEC = 12;

  typedef struct {
    logic [15:0] x;
    logic [1:0]  mode;
    int          seg;
    int          x0;
    int          x1;
    int          y0;
    int          y1;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] i_x_axis;
  logic [1:0]  i_mode;
  logic        i_frame_tick;
  logic        i_waiting;
  logic        o_clear, o_start, o_busy;
  logic [15:0] o_x0, o_y0, o_x1, o_y1;
  logic [2:0]  o_seg_idx;
  logic [7:0]  o_drop_cnt;
  logic [2:0]  o_state;

  int n_checks = 0;
  int n_pass   = 0;
  int clr_cnt  = 0;
  int start_cnt = 0;
  int cap_x0[NUM_SEG], cap_x1[NUM_SEG], cap_y0[NUM_SEG], cap_y1[NUM_SEG];
  int ticks, clr_base, hold, exp_drop, guard;
  vec_t vecs[NUM_VEC];

  tilt_line_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .i_x_axis     (i_x_axis),
    .i_mode       (i_mode),
    .i_frame_tick (i_frame_tick),
    .i_waiting    (i_waiting),
    .o_clear      (o_clear),
    .o_start      (o_start),
    .o_x0         (o_x0),
    .o_y0         (o_y0),
    .o_x1         (o_x1),
    .o_y1         (o_y1),
    .o_busy       (o_busy),
    .o_seg_idx    (o_seg_idx),
    .o_drop_cnt   (o_drop_cnt),
    .o_state      (o_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- pulse monitor ----------------
  always @(negedge clk) begin
    if (o_clear === 1'b1) clr_cnt++;
    if (o_start === 1'b1) start_cnt++;
    if (o_clear === 1'b1 && o_start === 1'b1) begin
      n_checks++;
      $display("FAIL pulse_overlap: o_clear=%0b o_start=%0b required not both high", o_clear, o_start);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0d required %0d", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  function automatic int clampi(input int v, input int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic void ref_seg(input logic [15:0] x, input logic [1:0] mode, input int k,
                                  output int y0, output int y1);
    int xi, inc, d, base;
    xi = int'($signed(x));
    // Floor division by 16 == arithmetic shift right by 4.
    if (xi >= 0) inc = xi / 16;
    else inc = -((-xi + 15) / 16);
    case (mode)
      2'd1:    d = (k % 2 == 1) ? -inc : inc;
      2'd2:    d = inc * (k + 1);
      default: d = inc;
    endcase
    base = 200 + 40 * k;
    y0 = clampi(base + d, 479);
    y1 = clampi(base - d, 479);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic scramble();
    i_x_axis = 16'($urandom);
    i_mode   = 2'($urandom_range(0, 3));
  endtask

  task automatic run_frame(input logic [15:0] x, input logic [1:0] mode, input int hold_cyc);
    int clr0, st0, y0e, y1e, g;
    @(negedge clk);
    i_x_axis = x; i_mode = mode; i_waiting = 1'b1; i_frame_tick = 1'b1;
    clr0 = clr_cnt; st0 = start_cnt;
    @(negedge clk);
    i_frame_tick = 1'b0;
    g = 0;
    while (o_clear !== 1'b1 && g < 20) begin @(negedge clk); g++; end
    if (o_clear !== 1'b1) begin check("clear_timeout", 0, 1); return; end
    for (int k = 0; k < NUM_SEG; k++) begin
      g = 0;
      while (o_start !== 1'b1 && g < 200) begin @(negedge clk); scramble(); g++; end
      if (o_start !== 1'b1) begin check("start_timeout", 0, 1); return; end
      ref_seg(x, mode, k, y0e, y1e);
      cap_x0[k] = int'(o_x0); cap_x1[k] = int'(o_x1);
      cap_y0[k] = int'(o_y0); cap_y1[k] = int'(o_y1);
      check($sformatf("seg_idx_%0d", k), {29'b0, o_seg_idx}, k);
      check($sformatf("x0_seg%0d", k), {16'b0, o_x0}, 250);
      check($sformatf("x1_seg%0d", k), {16'b0, o_x1}, 400);
      check($sformatf("y0_seg%0d", k), {16'b0, o_y0}, y0e);
      check($sformatf("y1_seg%0d", k), {16'b0, o_y1}, y1e);
      check($sformatf("clear_before_start%0d", k), clr_cnt - clr0, 1);
      i_waiting = 1'b0;
      repeat (hold_cyc) begin @(negedge clk); scramble(); end
      i_waiting = 1'b1;
      @(negedge clk);
    end
    g = 0;
    while (o_busy !== 1'b0 && g < 50) begin @(negedge clk); g++; end
    check("frame_end_idle", {31'b0, o_busy}, 0);
    check("frame_clears", clr_cnt - clr0, 1);
    check("frame_starts", start_cnt - st0, NUM_SEG);
    check("frame_no_drops", {24'b0, o_drop_cnt}, 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    vecs[0]  = '{16'd256,   2'd0, 0, 250, 400, 216, 184};
    vecs[1]  = '{16'd256,   2'd0, 1, 250, 400, 256, 224};
    vecs[2]  = '{16'd256,   2'd0, 2, 250, 400, 296, 264};
    vecs[3]  = '{16'd256,   2'd0, 3, 250, 400, 336, 304};
    vecs[4]  = '{16'h8000,  2'd0, 0, 250, 400, 0,   479};
    vecs[5]  = '{16'd160,   2'd1, 1, 250, 400, 230, 250};
    vecs[6]  = '{16'd160,   2'd1, 2, 250, 400, 290, 270};
    vecs[7]  = '{16'd160,   2'd2, 1, 250, 400, 260, 220};
    vecs[8]  = '{16'd160,   2'd2, 3, 250, 400, 360, 280};
    vecs[9]  = '{16'd256,   2'd3, 1, 250, 400, 256, 224};
    vecs[10] = '{16'h8000,  2'd2, 3, 250, 400, 0,   479};
    vecs[11] = '{16'hFFEF,  2'd0, 0, 250, 400, 198, 202};

    rst = 1'b1; i_x_axis = '0; i_mode = '0; i_frame_tick = 1'b0; i_waiting = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'b0, o_busy}, 0);
    check("rst_clear", {31'b0, o_clear}, 0);
    check("rst_start", {31'b0, o_start}, 0);
    check("rst_seg_idx", {29'b0, o_seg_idx}, 0);
    check("rst_drop", {24'b0, o_drop_cnt}, 0);
    check("rst_x0", {16'b0, o_x0}, 0);
    check("rst_y0", {16'b0, o_y0}, 0);
    check("rst_x1", {16'b0, o_x1}, 0);
    check("rst_y1", {16'b0, o_y1}, 0);
    check("rst_state", {29'b0, o_state}, 0);
    rst = 1'b0; i_waiting = 1'b1;
    @(negedge clk);
    check("post_rst_clear", {31'b0, o_clear}, 0);
    check("post_rst_start", {31'b0, o_start}, 0);
    check("post_rst_busy", {31'b0, o_busy}, 0);

    // Vector table of hand-derived endpoints.
    for (int i = 0; i < NUM_VEC; i++) begin
      run_frame(vecs[i].x, vecs[i].mode, 2);
      check($sformatf("vec%0d_x0", i), cap_x0[vecs[i].seg], vecs[i].x0);
      check($sformatf("vec%0d_x1", i), cap_x1[vecs[i].seg], vecs[i].x1);
      check($sformatf("vec%0d_y0", i), cap_y0[vecs[i].seg], vecs[i].y0);
      check($sformatf("vec%0d_y1", i), cap_y1[vecs[i].seg], vecs[i].y1);
    end

    // Randomized frames against the model.
    for (int i = 0; i < 20; i++)
      run_frame(16'($urandom), 2'($urandom_range(0, 3)), $urandom_range(0, 6));

    // Reset while waiting on segment 2's draw.
    @(negedge clk);
    i_x_axis = 16'd256; i_mode = 2'd0; i_waiting = 1'b1; i_frame_tick = 1'b1;
    @(negedge clk);
    i_frame_tick = 1'b0;
    guard = 0;
    while (!(o_start === 1'b1 && o_seg_idx == 3'd2) && guard < 200) begin @(negedge clk); guard++; end
    check("mid_rst_reach_seg2", {31'b0, o_start}, 1);
    i_waiting = 1'b0;
    @(negedge clk);
    check("mid_rst_in_wait_draw", {29'b0, o_state}, 6);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_busy", {31'b0, o_busy}, 0);
    check("mid_rst_seg_idx", {29'b0, o_seg_idx}, 0);
    check("mid_rst_state", {29'b0, o_state}, 0);
    check("mid_rst_y0", {16'b0, o_y0}, 0);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_no_clear", {31'b0, o_clear}, 0);
    check("mid_rst_no_start", {31'b0, o_start}, 0);
    i_waiting = 1'b1;
    run_frame(16'd256, 2'd0, 1);

    // Drop counting: ticks every 5 cycles, drawer slow (20 cycles per segment).
    clr_base = clr_cnt; ticks = 0; hold = 0; i_waiting = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      i_frame_tick = (c % 5 == 0);
      if (c % 5 == 0) ticks++;
      if (o_start === 1'b1) begin
        hold = 20; i_waiting = 1'b0;
      end else if (hold > 0) begin
        hold--;
        if (hold == 0) i_waiting = 1'b1;
      end
      if (c % 5 == 4) begin
        exp_drop = ticks - (clr_cnt - clr_base);
        if (exp_drop > 255) exp_drop = 255;
        check("drop_cnt", {24'b0, o_drop_cnt}, exp_drop);
      end
    end
    i_frame_tick = 1'b0; i_waiting = 1'b1;
    guard = 0;
    while (o_busy !== 1'b0 && guard < 500) begin @(negedge clk); guard++; end
    check("drop_final_idle", {31'b0, o_busy}, 0);
    check("drop_saturated", {24'b0, o_drop_cnt}, 255);
    check("drop_ticks_exceed", (ticks - (clr_cnt - clr_base)) > 255 ? 1 : 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
